// File: rtl/fejkon_fc_stats.sv
// Frame statistics tap for the 256-bit FC Avalon-ST stream: a one-deep register
// slice plus saturating per-channel frame/byte/error counters behind a CSR slave.
module fejkon_fc_stats #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   st_in_channel,
  input  logic [255:0] st_in_data,
  input  logic         st_in_startofpacket,
  input  logic         st_in_endofpacket,
  input  logic [4:0]   st_in_empty,
  input  logic         st_in_valid,
  output logic         st_in_ready,
  output logic [3:0]   st_out_channel,
  output logic [255:0] st_out_data,
  output logic         st_out_startofpacket,
  output logic         st_out_endofpacket,
  output logic [4:0]   st_out_empty,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  input  logic [7:0]   csr_address,
  input  logic         csr_write,
  input  logic         csr_read,
  input  logic [31:0]  csr_writedata,
  output logic [31:0]  csr_readdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [5:0] inc);
    logic [32:0] sum;
    sum = 33'(v) + 33'(inc);
    if (sum > 33'(CNT_MAX)) return CNT_MAX;
    return sum[CNT_W-1:0];
  endfunction

  logic [3:0]   out_channel_q, out_channel_d;
  logic [255:0] out_data_q, out_data_d;
  logic         out_sop_q, out_sop_d;
  logic         out_eop_q, out_eop_d;
  logic [4:0]   out_empty_q, out_empty_d;
  logic         out_valid_q, out_valid_d;

  logic [CNT_W-1:0]    frames_q [CHANNELS];
  logic [CNT_W-1:0]    frames_d [CHANNELS];
  logic [CNT_W-1:0]    bytes_q  [CHANNELS];
  logic [CNT_W-1:0]    bytes_d  [CHANNELS];
  logic [CNT_W-1:0]    err_q    [CHANNELS];
  logic [CNT_W-1:0]    err_d    [CHANNELS];
  logic [CHANNELS-1:0] in_pkt_q, in_pkt_d;
  logic [CNT_W-1:0]    bad_chan_q, bad_chan_d;
  logic [31:0]         readdata_q, readdata_d;

  logic       accepted;
  logic       clear;
  logic [5:0] beat_bytes;
  logic       unused_wdata;

  // Ready is held low during reset so nothing is accepted into a clearing slice.
  assign st_in_ready  = reset_n & (~out_valid_q | st_out_ready);
  assign accepted     = out_valid_q & st_out_ready;
  assign clear        = csr_write && (csr_address == 8'h00) && csr_writedata[0];
  assign beat_bytes   = out_eop_q ? (6'd32 - {1'b0, out_empty_q}) : 6'd32;
  assign unused_wdata = ^csr_writedata[31:1];

  always_comb begin
    out_channel_d = out_channel_q;
    out_data_d    = out_data_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_empty_d   = out_empty_q;
    out_valid_d   = out_valid_q;
    if (st_in_ready) begin
      out_channel_d = st_in_channel;
      out_data_d    = st_in_data;
      out_sop_d     = st_in_startofpacket;
      out_eop_d     = st_in_endofpacket;
      out_empty_d   = st_in_empty;
      out_valid_d   = st_in_valid;
    end
  end

  // SOP while open and non-SOP while closed are both framing errors; only the
  // orphan case skips byte counting and leaves the packet state alone.
  always_comb begin
    frames_d   = frames_q;
    bytes_d    = bytes_q;
    err_d      = err_q;
    in_pkt_d   = in_pkt_q;
    bad_chan_d = bad_chan_q;
    if (accepted && (32'(out_channel_q) >= CHANNELS)) bad_chan_d = sat_add(bad_chan_q, 6'd1);
    for (int c = 0; c < CHANNELS; c++) begin
      if (accepted && (32'(out_channel_q) == c)) begin
        if (out_sop_q == in_pkt_q[c]) err_d[c] = sat_add(err_q[c], 6'd1);
        if (out_sop_q || in_pkt_q[c]) begin
          bytes_d[c] = sat_add(bytes_q[c], beat_bytes);
          if (out_eop_q) begin
            frames_d[c] = sat_add(frames_q[c], 6'd1);
            in_pkt_d[c] = 1'b0;
          end else begin
            in_pkt_d[c] = 1'b1;
          end
        end
      end
    end
    if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        frames_d[c] = '0;
        bytes_d[c]  = '0;
        err_d[c]    = '0;
      end
      in_pkt_d   = '0;
      bad_chan_d = '0;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (csr_read) begin
      readdata_d = 32'hFFFF_FFFF;
      if (csr_address == 8'h00) begin
        readdata_d = {16'h0, 8'(CHANNELS), 8'h01};
      end else if (csr_address == 8'h01) begin
        readdata_d = 32'(bad_chan_q);
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (csr_address[7:2] == 6'(c + 4)) begin
            case (csr_address[1:0])
              2'd0:    readdata_d = 32'(frames_q[c]);
              2'd1:    readdata_d = 32'(bytes_q[c]);
              2'd2:    readdata_d = 32'(err_q[c]);
              default: readdata_d = {31'h0, in_pkt_q[c]};
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_channel_q <= '0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      out_valid_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        frames_q[c] <= '0;
        bytes_q[c]  <= '0;
        err_q[c]    <= '0;
      end
      in_pkt_q   <= '0;
      bad_chan_q <= '0;
      readdata_q <= '0;
    end else begin
      out_channel_q <= out_channel_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_empty_q   <= out_empty_d;
      out_valid_q   <= out_valid_d;
      frames_q      <= frames_d;
      bytes_q       <= bytes_d;
      err_q         <= err_d;
      in_pkt_q      <= in_pkt_d;
      bad_chan_q    <= bad_chan_d;
      readdata_q    <= readdata_d;
    end
  end

  assign st_out_channel       = out_channel_q;
  assign st_out_data          = out_data_q;
  assign st_out_startofpacket = out_sop_q;
  assign st_out_endofpacket   = out_eop_q;
  assign st_out_empty         = out_empty_q;
  assign st_out_valid         = out_valid_q;
  assign csr_readdata         = readdata_q;

endmodule

// File: tb/tb_fejkon_fc_stats.sv
// Bench for fejkon_fc_stats: two instances (32-bit and 4-bit counters) share one
// stimulus; a queue-based slice model and count-based statistics model predict both.
module tb_fejkon_fc_stats;

  localparam int CHANNELS = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   st_in_channel;
  logic [255:0] st_in_data;
  logic         st_in_startofpacket, st_in_endofpacket;
  logic [4:0]   st_in_empty;
  logic         st_in_valid;
  logic         st_out_ready;
  logic [7:0]   csr_address;
  logic         csr_write, csr_read;
  logic [31:0]  csr_writedata;

  logic         inReadyA, inReadyB;
  logic [3:0]   outChA, outChB;
  logic [255:0] outDataA, outDataB;
  logic         outSopA, outSopB, outEopA, outEopB;
  logic [4:0]   outEmptyA, outEmptyB;
  logic         outValidA, outValidB;
  logic [31:0]  readDataA, readDataB;

  always #5 clk = ~clk;

  fejkon_fc_stats #(.CHANNELS(CHANNELS), .CNT_W(32)) dutA (
    .clk(clk), .reset_n(reset_n),
    .st_in_channel(st_in_channel), .st_in_data(st_in_data),
    .st_in_startofpacket(st_in_startofpacket), .st_in_endofpacket(st_in_endofpacket),
    .st_in_empty(st_in_empty), .st_in_valid(st_in_valid), .st_in_ready(inReadyA),
    .st_out_channel(outChA), .st_out_data(outDataA),
    .st_out_startofpacket(outSopA), .st_out_endofpacket(outEopA),
    .st_out_empty(outEmptyA), .st_out_valid(outValidA), .st_out_ready(st_out_ready),
    .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
    .csr_writedata(csr_writedata), .csr_readdata(readDataA));

  fejkon_fc_stats #(.CHANNELS(CHANNELS), .CNT_W(4)) dutB (
    .clk(clk), .reset_n(reset_n),
    .st_in_channel(st_in_channel), .st_in_data(st_in_data),
    .st_in_startofpacket(st_in_startofpacket), .st_in_endofpacket(st_in_endofpacket),
    .st_in_empty(st_in_empty), .st_in_valid(st_in_valid), .st_in_ready(inReadyB),
    .st_out_channel(outChB), .st_out_data(outDataB),
    .st_out_startofpacket(outSopB), .st_out_endofpacket(outEopB),
    .st_out_empty(outEmptyB), .st_out_valid(outValidB), .st_out_ready(st_out_ready),
    .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
    .csr_writedata(csr_writedata), .csr_readdata(readDataB));

  typedef struct {
    logic [3:0]   ch;
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
  } beat_t;

  beat_t   slice[$];
  bit      readyQ[$];
  longint  framesM[16], bytesM[16], errM[16], badM;
  bit      inPktM[16];
  bit      readPending;
  logic [31:0] expReadA, expReadB;
  int      checks = 0;
  int      passes = 0;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  function automatic longint satTo(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected CSR word for a given counter width, from the unbounded model counts.
  function automatic logic [31:0] modelRead(input logic [7:0] addr, input int w);
    int c, r;
    if (addr == 8'h00) return {16'h0, 8'(CHANNELS), 8'h01};
    if (addr == 8'h01) return 32'(satTo(badM, w));
    if (addr >= 8'h10) begin
      c = (int'(addr) - 16) / 4;
      r = int'(addr) % 4;
      if (c < CHANNELS) begin
        case (r)
          0: return 32'(satTo(framesM[c], w));
          1: return 32'(satTo(bytesM[c], w));
          2: return 32'(satTo(errM[c], w));
          default: return {31'h0, inPktM[c]};
        endcase
      end
    end
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clearModel();
    for (int c = 0; c < 16; c++) begin
      framesM[c] = 0; bytesM[c] = 0; errM[c] = 0; inPktM[c] = 0;
    end
    badM = 0;
  endtask

  task automatic modelAccept(input beat_t b);
    int c;
    if (int'(b.ch) >= CHANNELS) begin
      badM++;
    end else begin
      c = int'(b.ch);
      if (b.sop && inPktM[c]) errM[c]++;
      if (!b.sop && !inPktM[c]) begin
        errM[c]++;
      end else begin
        bytesM[c] += b.eop ? (32 - int'(b.empty)) : 32;
        if (b.eop) begin
          framesM[c]++;
          inPktM[c] = 0;
        end else begin
          inPktM[c] = 1;
        end
      end
    end
  endtask

  // One clock: entered at a falling edge with inputs set, leaves at the next one.
  task automatic tick(output bit inAccepted);
    beat_t b;
    bit expValid, inRdyExp;
    if (readyQ.size() > 0) st_out_ready = readyQ.pop_front();
    #1;
    if (readPending) begin
      checkOutput("csr_rd_a", readDataA, expReadA);
      checkOutput("csr_rd_b", readDataB, expReadB);
      readPending = 0;
    end
    expValid = slice.size() > 0;
    checkOutput("out_valid_a", outValidA, expValid);
    checkOutput("out_valid_b", outValidB, expValid);
    if (expValid) begin
      checkOutput("out_data", outDataA, slice[0].data);
      checkOutput("out_ctrl", {outChA, outSopA, outEopA, outEmptyA},
                  {slice[0].ch, slice[0].sop, slice[0].eop, slice[0].empty});
    end
    inRdyExp = !expValid || st_out_ready;
    checkOutput("in_ready_a", inReadyA, inRdyExp);
    checkOutput("in_ready_b", inReadyB, inRdyExp);
    if (csr_read) begin
      expReadA = modelRead(csr_address, 32);
      expReadB = modelRead(csr_address, 4);
      readPending = 1;
    end
    if (expValid && st_out_ready) modelAccept(slice.pop_front());
    inAccepted = inRdyExp && st_in_valid;
    if (inAccepted) begin
      b.ch = st_in_channel; b.data = st_in_data; b.sop = st_in_startofpacket;
      b.eop = st_in_endofpacket; b.empty = st_in_empty;
      slice.push_back(b);
    end
    if (csr_write && csr_address == 8'h00 && csr_writedata[0]) clearModel();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    st_in_valid = 0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  // Drives one beat and holds it until the slice takes it.
  task automatic applyStimulus(input logic [3:0] ch, input bit sop, input bit eop, input logic [4:0] empty);
    bit acc;
    int n;
    st_in_channel = ch; st_in_startofpacket = sop; st_in_endofpacket = eop;
    st_in_empty = empty; st_in_data = {8{$urandom()}}; st_in_valid = 1;
    acc = 0; n = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    if (!acc) checkOutput("beat_accept_timeout", 0, 1);
    st_in_valid = 0;
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr, input logic [31:0] exp, input bit onB);
    bit acc;
    csr_read = 1; csr_address = addr;
    tick(acc);
    csr_read = 0;
    tick(acc);
    checkOutput(tag, onB ? readDataB : readDataA, exp);
  endtask

  task automatic clearAll();
    bit acc;
    csr_write = 1; csr_address = 8'h00; csr_writedata = 32'h1;
    tick(acc);
    csr_write = 0;
  endtask

  initial begin
    bit acc;
    reset_n = 0; st_in_valid = 0; st_in_channel = 0; st_in_data = '0;
    st_in_startofpacket = 0; st_in_endofpacket = 0; st_in_empty = 0;
    st_out_ready = 1; csr_address = 0; csr_write = 0; csr_read = 0; csr_writedata = 0;
    readPending = 0;
    clearModel();
    @(negedge clk); @(negedge clk);
    checkOutput("rst_in_ready", inReadyA, 0);
    checkOutput("rst_out_valid", outValidA, 0);
    checkOutput("rst_readdata", readDataA, 0);
    reset_n = 1;
    idle(1);
    readCheck("id_word", 8'h00, 32'h0000_0401, 0);

    // Three-beat frame on channel 2 under constant ready.
    applyStimulus(4'd2, 1, 0, 5'd0);
    applyStimulus(4'd2, 0, 0, 5'd0);
    applyStimulus(4'd2, 0, 1, 5'd4);
    idle(2);
    readCheck("frames2", 8'h18, 32'd1, 0);
    readCheck("bytes2", 8'h19, 32'd92, 0);
    readCheck("err2", 8'h1A, 32'd0, 0);
    readCheck("inpkt2", 8'h1B, 32'd0, 0);

    // Four-beat frame on channel 0 with downstream ready toggling.
    clearAll();
    readyQ = '{1, 0, 0, 1, 1, 0, 1};
    applyStimulus(4'd0, 1, 0, 5'd0);
    applyStimulus(4'd0, 0, 0, 5'd0);
    applyStimulus(4'd0, 0, 0, 5'd0);
    applyStimulus(4'd0, 0, 1, 5'd0);
    readyQ.delete();
    st_out_ready = 1;
    idle(3);
    readCheck("frames0", 8'h10, 32'd1, 0);
    readCheck("bytes0", 8'h11, 32'd128, 0);

    // Missing EOP followed by an orphan beat on channel 1.
    clearAll();
    applyStimulus(4'd1, 1, 0, 5'd0);
    applyStimulus(4'd1, 1, 0, 5'd0);
    applyStimulus(4'd1, 0, 1, 5'd0);
    applyStimulus(4'd1, 0, 1, 5'd7);
    idle(2);
    readCheck("err1", 8'h16, 32'd2, 0);
    readCheck("frames1", 8'h14, 32'd1, 0);
    readCheck("bytes1", 8'h15, 32'd96, 0);

    // Out-of-range channel only touches the bad-channel counter.
    applyStimulus(4'd9, 1, 1, 5'd0);
    idle(2);
    readCheck("bad_chan", 8'h01, 32'd1, 0);
    readCheck("chan9_unmapped", 8'h34, 32'hFFFF_FFFF, 0);
    readCheck("frames1_kept", 8'h14, 32'd1, 0);
    readCheck("unmapped_lo", 8'h05, 32'hFFFF_FFFF, 0);

    // Saturation in the 4-bit instance, then clear racing an accepted EOP.
    clearAll();
    for (int i = 0; i < 20; i++) applyStimulus(4'd3, 1, 1, 5'd0);
    idle(2);
    readCheck("frames3_sat", 8'h1C, 32'd15, 1);
    readCheck("frames3_wide", 8'h1C, 32'd20, 0);
    readCheck("bytes3_sat", 8'h1D, 32'd15, 1);
    st_in_channel = 4'd3; st_in_startofpacket = 1; st_in_endofpacket = 1;
    st_in_empty = 0; st_in_valid = 1;
    tick(acc);
    st_in_valid = 0;
    csr_write = 1; csr_address = 8'h00; csr_writedata = 32'h1;
    tick(acc);
    csr_write = 0;
    idle(1);
    readCheck("clear_wins_b", 8'h1C, 32'd0, 1);
    readCheck("clear_wins_a", 8'h1C, 32'd0, 0);

    // Asynchronous reset in the middle of a channel-0 frame.
    applyStimulus(4'd0, 1, 0, 5'd0);
    applyStimulus(4'd0, 0, 0, 5'd0);
    st_out_ready = 0;
    tick(acc);
    readCheck("inpkt0_open", 8'h13, 32'd1, 0);
    #2 reset_n = 0;
    #1;
    checkOutput("midrst_out_valid", outValidA, 0);
    checkOutput("midrst_in_ready", inReadyA, 0);
    slice.delete();
    clearModel();
    readPending = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    st_out_ready = 1;
    readCheck("inpkt0_after_rst", 8'h13, 32'd0, 0);
    applyStimulus(4'd0, 1, 0, 5'd0);
    applyStimulus(4'd0, 0, 1, 5'd0);
    idle(2);
    readCheck("frames0_after_rst", 8'h10, 32'd1, 0);
    readCheck("err0_after_rst", 8'h12, 32'd0, 0);

    // Randomized traffic, backpressure, reads and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      st_in_valid = $urandom_range(0, 3) != 0;
      st_in_channel = 4'($urandom_range(0, 5));
      st_in_startofpacket = $urandom_range(0, 1) == 1;
      st_in_endofpacket = $urandom_range(0, 2) == 0;
      st_in_empty = 5'($urandom());
      st_in_data = {8{$urandom()}};
      st_out_ready = $urandom_range(0, 3) != 0;
      csr_read = $urandom_range(0, 3) == 0;
      csr_write = $urandom_range(0, 63) == 0;
      if (csr_write) csr_address = $urandom_range(0, 1) ? 8'h00 : 8'($urandom());
      else if ($urandom_range(0, 3) == 0) csr_address = 8'($urandom());
      else csr_address = 8'(8'h10 + $urandom_range(0, 23));
      csr_writedata = $urandom();
      tick(acc);
    end
    csr_read = 0; csr_write = 0; st_out_ready = 1;
    idle(3);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
